ram_sp2: RTL and testbench
==========================

# ram_sp2

Synchronous behavioural RAM model for the primitives test library, the functional successor of the black-box RAM cell: one write port, one read port, parametrised width, depth, read latency, clock polarity and read-during-write policy. After reset it runs a power-on clear sweep that zeroes every word before accepting traffic. It is used as a simulatable RAM leaf in netlists exercised by the Verilog backend tests.

## Interface
- WIDTH, 56, data word width in bits (1..1024).
- DEPTH, 256, number of words (2..65536, need not be a power of two); AW = clog2(DEPTH) address bits.
- INVERTED_CLK, "FALSE", "TRUE" makes every register (reset sampling included) update on the falling edge of CLK.
- READ_LATENCY, 1, 1 or 2 register stages from read request to Q.
- RDW_MODE, "OLD", same-address read and write on one edge: "OLD" returns the previous contents, "NEW" returns the write data.
- CLEAR_ON_RESET, "TRUE", "FALSE" skips the clear sweep; memory contents are undefined after reset.
- CLK  input  1  clock; the active edge is set by INVERTED_CLK.
- RSTN  input  1  reset, synchronous, active-low.
- WE  input  1  write enable.
- WA  input  AW  write address.
- WD  input  WIDTH  write data.
- RE  input  1  read enable.
- RA  input  AW  read address.
- Q  output  WIDTH  read data, held between reads.
- QV  output  1  one-cycle pulse, Q carries new read data.
- BUSY  output  1  clear sweep in progress; WE and RE are ignored.

## Operation
- States: CLEAR and READY. RSTN low at an active edge forces CLEAR (READY if CLEAR_ON_RESET="FALSE"), clear counter 0, Q=0, QV=0, pipeline valid bits 0, BUSY=1 (0 if no clear).
- CLEAR, RSTN high: each active edge writes 0 to mem[counter] and increments the counter. The edge that writes address DEPTH-1 moves to READY; BUSY is low from the next cycle. The sweep takes exactly DEPTH edges after reset release.
- While BUSY=1: WE and RE are ignored, QV=0, Q keeps its value of 0.
- READY: WE=1 and WA<DEPTH writes WD to mem[WA]. WA>=DEPTH: the write is dropped.
- READY: RE=1 accepts a read. RA>=DEPTH returns all zeros, and QV still pulses.
- Same edge with WE, RE and WA==RA: the result follows RDW_MODE. Different addresses are independent.
- Reads are fully pipelined: one read per edge, with no stalls and no backpressure.
- Reset mid-sweep restarts the sweep from address 0. Reset while a read is in flight drops that read (no QV).
- Memory contents are not cleared by reset when CLEAR_ON_RESET="FALSE".

## Timing
- All inputs are sampled at the active edge: rising edge, or falling edge for INVERTED_CLK="TRUE".
- A read accepted at edge k loads Q and sets QV at edge k+READ_LATENCY-1. Q is valid in the following cycle, i.e. READ_LATENCY cycles after the request cycle.
- QV is high for exactly one cycle per accepted read. Back-to-back reads produce back-to-back QV.
- A write at edge k is visible to any read accepted at edge k+1 or later. At edge k the result is set by RDW_MODE.
- BUSY falls in the cycle after the final clear edge. A read or write issued in the first READY cycle is accepted.
- Output reset values: Q=0, QV=0, BUSY=1 (0 when CLEAR_ON_RESET="FALSE").

## Test plan
- Reset and clear, defaults (DEPTH=256): release RSTN. Required: BUSY high for 256 cycles then low. Reading addresses 0, 128 and 255 returns 0 with QV one cycle later.
- Write then read, WIDTH=56: write 0xAB_CDEF_0123_4567 to address 17, then read 17 on the next edge. Required: Q equals the written value and QV pulses once, 1 cycle after RE for READ_LATENCY=1 and 2 cycles for READ_LATENCY=2.
- Read-during-write: address 5 holds 0x11, then write 0x22 and read address 5 on the same edge. Required: Q=0x11 with RDW_MODE="OLD", Q=0x22 with "NEW". A following read of 5 returns 0x22.
- Non-power-of-two depth (DEPTH=100): write to address 120. Required: the write is dropped, a read of 120 returns 0 with QV=1, and the sweep lasts 100 cycles.
- Reset mid-operation: assert RSTN low at sweep address 40, and again with a READ_LATENCY=2 read in flight. Required: the sweep restarts and runs a full DEPTH cycles; the in-flight read never asserts QV; Q=0.
- INVERTED_CLK="TRUE": repeat the write/read scenario. Required: state changes only on falling edges, with the same cycle counts.

Source files
------------

// File: rtl/ram_sp2.sv
// ram_sp2: synchronous single-write / single-read RAM model.
// After reset a clear sweep writes zero to every word, one word per active
// edge, before the RAM accepts traffic. Reads are fully pipelined with a
// latency of one or two register stages. Same-address read/write collisions
// return either the old contents or the write data.
module ram_sp2 #(
  parameter int    WIDTH          = 56,
  parameter int    DEPTH          = 256,
  parameter string INVERTED_CLK   = "FALSE",
  parameter int    READ_LATENCY   = 1,
  parameter string RDW_MODE       = "OLD",
  parameter string CLEAR_ON_RESET = "TRUE",
  localparam int   AW             = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic             RE,
  input  logic [AW-1:0]    RA,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             BUSY
);

  localparam bit            CLK_INV   = (INVERTED_CLK == "TRUE");
  localparam bit            RDW_NEW   = (RDW_MODE == "NEW");
  localparam bit            DO_CLEAR  = (CLEAR_ON_RESET != "FALSE");
  localparam bit            LAT_ONE   = (READ_LATENCY == 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    clr_cnt_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_vld_q;
  logic [WIDTH-1:0] q_q;
  logic             qv_q;
  logic             clk_act;
  logic             wa_ok;
  logic             ra_ok;
  logic             ready;
  logic             wr_acc;
  logic             rd_acc;

  // Every register in the block, reset sampling included, runs off this edge.
  assign clk_act = CLK_INV ? ~CLK : CLK;

  // Address range checks only exist when DEPTH leaves unused address codes.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign wa_ok = 1'b1;
    assign ra_ok = 1'b1;
  end else begin : g_partial_range
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    assign wa_ok = (WA < DEPTH_A);
    assign ra_ok = (RA < DEPTH_A);
  end

  assign ready  = (state_q == ST_READY);
  assign wr_acc = ready && WE && wa_ok;
  assign rd_acc = ready && RE;

  // Clear-sweep FSM: walks the counter through every word, then idles in READY.
  always_ff @(posedge clk_act) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (!RSTN) begin
      state_q   <= DO_CLEAR ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_q <= ST_READY;
      end
      clr_cnt_q <= clr_cnt_q + AW'(1);
    end
  end

  // Storage array: zeroed by the sweep, then written by the write port.
  always_ff @(posedge clk_act) begin
    // NOTE: the array has no reset branch; it is cleared by the sweep so it
    // can map onto a RAM macro rather than thousands of resettable flops.
    if (RSTN) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_acc) begin
        mem[WA] <= WD;
      end
    end
  end

  // Read data for this edge: out-of-range gives zero, collisions follow RDW_MODE.
  always_comb begin
    // NOTE: default first so no path leaves rdata_d unassigned (no latch).
    rdata_d = '0;
    if (ra_ok) begin
      if (RDW_NEW && wr_acc && (WA == RA)) begin
        rdata_d = WD;
      end else begin
        rdata_d = mem[RA];
      end
    end
  end

  // Read pipeline: one stage for latency 1, an extra holding stage for latency 2.
  always_ff @(posedge clk_act) begin
    if (!RSTN) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
      q_q       <= '0;
      qv_q      <= 1'b0;
    end else begin
      s1_vld_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rdata_d;
      end
      if (LAT_ONE) begin
        qv_q <= rd_acc;
        if (rd_acc) begin
          q_q <= rdata_d;
        end
      end else begin
        qv_q <= s1_vld_q;
        if (s1_vld_q) begin
          q_q <= s1_data_q;
        end
      end
    end
  end

  assign Q    = q_q;
  assign QV   = qv_q;
  assign BUSY = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sp2.sv
// tb_ram_sp2: drives three ram_sp2 configurations with one shared stimulus
// stream and compares every output, every cycle, against a reference model.
//   dut 0: DEPTH 256, latency 1, RDW OLD, rising edge
//   dut 1: DEPTH 100, latency 2, RDW NEW, rising edge
//   dut 2: DEPTH 256, latency 2, RDW OLD, falling edge
module tb_ram_sp2;
  localparam int W = 56;
  localparam int N = 3;

  logic         clk;
  logic         rstn;
  logic         we;
  logic [7:0]   wa;
  logic [W-1:0] wd;
  logic         re;
  logic [7:0]   ra;
  logic [W-1:0] q_w    [N];
  logic         qv_w   [N];
  logic         busy_w [N];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int depth_c [N] = '{256, 100, 256};
  int lat_c   [N] = '{1, 2, 2};
  int aw_c    [N] = '{8, 7, 8};
  bit new_c   [N] = '{1'b0, 1'b1, 1'b0};

  // Reference model state
  logic [W-1:0] mem_m  [N][256];
  logic [W-1:0] q_m    [N];
  logic         qv_m   [N];
  int           rem_m  [N];
  int           edge_m [N];
  logic         pv_m   [N][4];
  logic [W-1:0] pd_m   [N][4];

  ram_sp2 #(.WIDTH(W), .DEPTH(256), .INVERTED_CLK("FALSE"), .READ_LATENCY(1),
            .RDW_MODE("OLD"), .CLEAR_ON_RESET("TRUE")) u_dut0 (
    .CLK(clk), .RSTN(rstn), .WE(we), .WA(wa), .WD(wd), .RE(re), .RA(ra),
    .Q(q_w[0]), .QV(qv_w[0]), .BUSY(busy_w[0]));

  ram_sp2 #(.WIDTH(W), .DEPTH(100), .INVERTED_CLK("FALSE"), .READ_LATENCY(2),
            .RDW_MODE("NEW"), .CLEAR_ON_RESET("TRUE")) u_dut1 (
    .CLK(clk), .RSTN(rstn), .WE(we), .WA(wa[6:0]), .WD(wd), .RE(re), .RA(ra[6:0]),
    .Q(q_w[1]), .QV(qv_w[1]), .BUSY(busy_w[1]));

  ram_sp2 #(.WIDTH(W), .DEPTH(256), .INVERTED_CLK("TRUE"), .READ_LATENCY(2),
            .RDW_MODE("OLD"), .CLEAR_ON_RESET("TRUE")) u_dut2 (
    .CLK(clk), .RSTN(rstn), .WE(we), .WA(wa), .WD(wd), .RE(re), .RA(ra),
    .Q(q_w[2]), .QV(qv_w[2]), .BUSY(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One active edge of configuration d, computed from the behavioural rules:
  // reset schedules a DEPTH-edge blackout after which the array reads as zero;
  // an accepted read delivers its data LAT-1 edges later.
  function automatic void model_edge(int d);
    int           wam;
    int           ram;
    int           slot;
    logic [W-1:0] rd;
    wam = int'(wa) & ((1 << aw_c[d]) - 1);
    ram = int'(ra) & ((1 << aw_c[d]) - 1);
    edge_m[d]++;
    if (!rstn) begin
      rem_m[d] = depth_c[d];
      for (int i = 0; i < 4; i++) pv_m[d][i] = 1'b0;
      q_m[d]  = '0;
      qv_m[d] = 1'b0;
      return;
    end
    if (rem_m[d] > 0) begin
      rem_m[d]--;
      if (rem_m[d] == 0) begin
        for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
      end
      qv_m[d] = 1'b0;
      return;
    end
    if (re) begin
      if (ram >= depth_c[d])                       rd = '0;
      else if (new_c[d] && we && wam == ram)       rd = wd;
      else                                         rd = mem_m[d][ram];
      slot = (edge_m[d] + lat_c[d] - 1) % 4;
      pv_m[d][slot] = 1'b1;
      pd_m[d][slot] = rd;
    end
    if (we && wam < depth_c[d]) mem_m[d][wam] = wd;
    slot = edge_m[d] % 4;
    if (pv_m[d][slot]) begin
      q_m[d]  = pd_m[d][slot];
      qv_m[d] = 1'b1;
      pv_m[d][slot] = 1'b0;
    end else begin
      qv_m[d] = 1'b0;
    end
  endfunction

  task automatic compare_dut(input int d, input string where);
    check($sformatf("%s q%0d", where, d),    64'(q_w[d]),    64'(q_m[d]));
    check($sformatf("%s qv%0d", where, d),   64'(qv_w[d]),   64'(qv_m[d]));
    check($sformatf("%s busy%0d", where, d), 64'(busy_w[d]), 64'(rem_m[d] > 0));
  endtask

  // One clock cycle: dut 2 acts on the falling edge, duts 0/1 on the rising
  // edge. Dut 2 is checked after its edge and again after the rising edge to
  // catch any update on the wrong edge.
  task automatic step();
    @(negedge clk);
    model_edge(2);
    #1;
    if (chk_en) begin
      compare_dut(2, "fall");
      compare_dut(0, "mid");
      compare_dut(1, "mid");
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    if (chk_en) compare_dut(2, "rise");
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic rand_inputs();
    we = 1'($urandom_range(0, 1));
    re = 1'($urandom_range(0, 1));
    wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
    ra = ($urandom_range(0, 7) == 0) ? wa : 8'($urandom_range(0, 255));
    wd = W'({$urandom(), $urandom()});
  endtask

  initial begin
    logic [W-1:0] v17;
    int           busy_cnt [N];
    v17 = 56'hAB_CDEF_0123_4567;
    for (int d = 0; d < N; d++) begin
      rem_m[d]  = 0;
      edge_m[d] = 0;
      q_m[d]    = '0;
      qv_m[d]   = 1'b0;
      busy_cnt[d] = 0;
      for (int i = 0; i < 4; i++) pv_m[d][i] = 1'b0;
    end
    rstn = 1'b0;
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;

    // Reset state
    step();
    chk_en = 1'b1;
    step();
    step();
    check("rst busy0", 64'(busy_w[0]), 64'd1);
    check("rst q1", 64'(q_w[1]), 64'd0);
    check("rst qv2", 64'(qv_w[2]), 64'd0);

    // Release; random traffic during the sweep must be ignored
    rstn = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < N; d++) if (busy_w[d]) busy_cnt[d]++;
      rand_inputs();
      step();
    end
    check("sweep len0", 64'(busy_cnt[0]), 64'd256);
    check("sweep len1", 64'(busy_cnt[1]), 64'd100);
    check("sweep len2", 64'(busy_cnt[2]), 64'd256);

    // Cleared words read back as zero with QV one cycle later (dut 0)
    idle();
    for (int i = 0; i < 3; i++) begin
      re = 1'b1;
      ra = (i == 0) ? 8'd0 : (i == 1) ? 8'd128 : 8'd255;
      step();
      check("clr rd q0", 64'(q_w[0]), 64'd0);
      check("clr rd qv0", 64'(qv_w[0]), 64'd1);
    end

    // Write 17, read 17 on the next edge
    idle();
    we = 1'b1; wa = 8'd17; wd = v17;
    step();
    we = 1'b0; re = 1'b1; ra = 8'd17;
    step();
    check("wr17 q0", 64'(q_w[0]), 64'(v17));
    check("wr17 qv0", 64'(qv_w[0]), 64'd1);
    check("wr17 qv1 early", 64'(qv_w[1]), 64'd0);
    idle();
    step();
    check("wr17 q1", 64'(q_w[1]), 64'(v17));
    check("wr17 qv1", 64'(qv_w[1]), 64'd1);
    check("wr17 qv0 once", 64'(qv_w[0]), 64'd0);

    // Read-during-write at address 5
    we = 1'b1; wa = 8'd5; wd = W'(8'h11);
    step();
    wd = W'(8'h22); re = 1'b1; ra = 8'd5;
    step();
    check("rdw q0 old", 64'(q_w[0]), 64'h11);
    we = 1'b0;
    step();
    check("rdw q1 new", 64'(q_w[1]), 64'h22);
    check("rdw q0 after", 64'(q_w[0]), 64'h22);
    idle();
    step();
    check("rdw q1 after", 64'(q_w[1]), 64'h22);

    // Address 120: beyond DEPTH for dut 1 (dropped), valid for dut 0
    we = 1'b1; wa = 8'd120; wd = v17 ^ 56'h5A5A;
    step();
    we = 1'b0; re = 1'b1; ra = 8'd120;
    step();
    check("oor q0", 64'(q_w[0]), 64'(v17 ^ 56'h5A5A));
    idle();
    step();
    check("oor q1", 64'(q_w[1]), 64'd0);
    check("oor qv1", 64'(qv_w[1]), 64'd1);

    // Random traffic
    for (int c = 0; c < 1200; c++) begin
      rand_inputs();
      step();
    end

    // Reset mid-sweep, then again after the sweep with a read in flight
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int c = 0; c < 40; c++) begin rand_inputs(); step(); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int c = 0; c < 300; c++) begin rand_inputs(); step(); end
    idle();
    re = 1'b1; ra = 8'd17;
    step();
    re = 1'b0; rstn = 1'b0;
    step();
    check("flight qv1", 64'(qv_w[1]), 64'd0);
    check("flight q1", 64'(q_w[1]), 64'd0);
    rstn = 1'b1;
    step();
    check("flight qv1 late", 64'(qv_w[1]), 64'd0);
    for (int c = 0; c < 300; c++) begin rand_inputs(); step(); end

    for (int c = 0; c < 500; c++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
